// File: rtl/alu_md.sv
// alu_md: execute-stage ALU with iterative multiply/divide and HI/LO registers.
// Single-cycle ops retire from IDLE; MULT/DIV take WIDTH steps in ITER, then FIN.
module alu_md #(
    parameter int WIDTH = 32,
    parameter int SA_W  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       alu_ctl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SA_W-1:0]  sa,
    output logic             out_valid,
    output logic [WIDTH-1:0] alu_out,
    output logic             overflow,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CNT_W = SA_W + 1;

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_XOR  = 4'd3;
    localparam logic [3:0] OP_NOR  = 4'd4;
    localparam logic [3:0] OP_SUB  = 4'd6;
    localparam logic [3:0] OP_SLT  = 4'd7;
    localparam logic [3:0] OP_SLL  = 4'd8;
    localparam logic [3:0] OP_SRA  = 4'd9;
    localparam logic [3:0] OP_MULT = 4'd10;
    localparam logic [3:0] OP_DIV  = 4'd11;
    localparam logic [3:0] OP_SRL  = 4'd12;
    localparam logic [3:0] OP_MFHI = 4'd13;
    localparam logic [3:0] OP_MFLO = 4'd14;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_FIN  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   shr_q, shr_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic               is_div_q, is_div_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   alu_out_q, alu_out_d;
    logic               overflow_q, overflow_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic [3:0]         op;
    logic               uns;
    logic               fire;
    logic               is_md;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH-1:0]   sum, diff, res;
    logic               ovf, lt;
    logic [WIDTH:0]     madd, dshift;
    logic               dgo;
    logic [2*WIDTH-1:0] prod;

    assign op    = alu_ctl[3:0];
    assign uns   = alu_ctl[4];
    assign fire  = in_valid && in_ready;
    assign is_md = (op == OP_MULT) || (op == OP_DIV);
    assign a_neg = !uns && a[WIDTH-1];
    assign b_neg = !uns && b[WIDTH-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;

    always_comb begin
        sum  = a + b;
        diff = a - b;
        lt   = uns ? (a < b) : ($signed(a) < $signed(b));
        res  = '0;
        ovf  = 1'b0;
        unique case (op)
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            OP_NOR:  res = ~(a | b);
            OP_ADD: begin
                res = sum;
                ovf = !uns && (a[WIDTH-1] == b[WIDTH-1])
                      && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                res = diff;
                ovf = !uns && (a[WIDTH-1] != b[WIDTH-1])
                      && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLT:  res = {{(WIDTH-1){1'b0}}, lt};
            OP_SLL:  res = b << sa;
            OP_SRA:  res = $signed(b) >>> sa;
            OP_SRL:  res = b >> sa;
            OP_MFHI: res = hi_q;
            OP_MFLO: res = lo_q;
            default: res = '0;
        endcase
    end

    // acc holds the running high half (MULT) or partial remainder (DIV)
    always_comb begin
        madd   = {1'b0, acc_q} + (shr_q[0] ? {1'b0, opb_q} : '0);
        dshift = {acc_q, shr_q[WIDTH-1]};
        dgo    = dshift >= {1'b0, opb_q};
        prod   = {acc_q, shr_q};
        if (neg_res_q)
            prod = -prod;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (fire && is_md) state_d = S_ITER;
            S_ITER: if (cnt_q == CNT_W'(1)) state_d = S_FIN;
            S_FIN:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        shr_d       = shr_q;
        opb_d       = opb_q;
        is_div_d    = is_div_q;
        neg_res_d   = neg_res_q;
        neg_rem_d   = neg_rem_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        alu_out_d   = alu_out_q;
        overflow_d  = overflow_q;
        out_valid_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (fire && is_md) begin
                    acc_d     = '0;
                    shr_d     = a_mag;
                    opb_d     = b_mag;
                    is_div_d  = (op == OP_DIV);
                    // a zero divisor must leave the all-ones quotient unsigned
                    neg_res_d = (a_neg ^ b_neg)
                                && !((op == OP_DIV) && (b == '0));
                    neg_rem_d = a_neg;
                    cnt_d     = CNT_W'(WIDTH);
                end else if (fire) begin
                    alu_out_d   = res;
                    overflow_d  = ovf;
                    out_valid_d = 1'b1;
                end
            end
            S_ITER: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (is_div_q) begin
                    acc_d = dgo ? (dshift[WIDTH-1:0] - opb_q)
                                : dshift[WIDTH-1:0];
                    shr_d = {shr_q[WIDTH-2:0], dgo};
                end else begin
                    acc_d = madd[WIDTH:1];
                    shr_d = {madd[0], shr_q[WIDTH-1:1]};
                end
            end
            S_FIN: begin
                if (is_div_q) begin
                    lo_d = neg_res_q ? -shr_q : shr_q;
                    hi_d = neg_rem_q ? -acc_q : acc_q;
                end else begin
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end
                alu_out_d   = lo_d;
                overflow_d  = 1'b0;
                out_valid_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            acc_q       <= '0;
            shr_q       <= '0;
            opb_q       <= '0;
            is_div_q    <= 1'b0;
            neg_res_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            out_valid_q <= 1'b0;
            alu_out_q   <= '0;
            overflow_q  <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
        end else begin
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            shr_q       <= shr_d;
            opb_q       <= opb_d;
            is_div_q    <= is_div_d;
            neg_res_q   <= neg_res_d;
            neg_rem_q   <= neg_rem_d;
            out_valid_q <= out_valid_d;
            alu_out_q   <= alu_out_d;
            overflow_q  <= overflow_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = out_valid_q;
    assign alu_out   = alu_out_q;
    assign overflow  = overflow_q;
    assign hi        = hi_q;
    assign lo        = lo_q;

endmodule

// File: doc/alu_md.md
# alu_md

Parametrised execute-stage ALU with an iterative multiply/divide unit and HI/LO registers. It keeps the single-cycle logic/arithmetic/shift operations and adds arithmetic shift, NOR, signed and unsigned compare, and signed-overflow detection. It also provides multi-cycle MULT/MULTU/DIV/DIVU with a valid/ready handshake. It sits in the EX stage; the pipeline control stalls issue while `in_ready` is low.

## Interface
- `WIDTH`, 32: operand/result width; must be even and ≥ 8.
- `SA_W`, 5: shift-amount width; equals log2(WIDTH).
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `in_valid`  in  1  operation presented this cycle.
- `in_ready`  out  1  combinational; high only in state IDLE. An operation is accepted on an edge where `in_valid && in_ready`.
- `alu_ctl`  in  5  [3:0] opcode; [4] = unsigned / no-trap modifier.
- `a`, `b`  in  WIDTH  operands.
- `sa`  in  SA_W  shift amount.
- `out_valid`  out  1  registered; one-cycle pulse per completed operation.
- `alu_out`  out  WIDTH  registered result; holds its value between pulses.
- `overflow`  out  1  registered; qualified by `out_valid`.
- `hi`, `lo`  out  WIDTH  registered HI/LO architectural registers.

## Operation
- Opcodes on `alu_ctl[3:0]`:
  - 0 AND, 1 OR, 2 ADD, 3 XOR, 4 NOR, 6 SUB.
  - 7 SLT: signed compare; unsigned when [4]=1.
  - 8 SLL `b<<sa`; 9 SRA, arithmetic `b>>>sa`; 12 SRL `b>>sa`.
  - 10 MULT, 11 DIV: signed, or unsigned when [4]=1.
  - 13 MFHI, 14 MFLO.
  - 5, 15: reserved; result 0, `overflow`=0.
- `overflow` is the signed overflow of ADD/SUB when [4]=0. It is 0 for every other case.
  - On overflow, `alu_out` still carries the wrapped result; the consumer suppresses writeback.
- States: IDLE, ITER, FIN.
  - IDLE, accepted single-cycle op → stay in IDLE; register result, `out_valid`=1 next cycle.
  - IDLE, accepted MULT/DIV → latch operand magnitudes and result signs; load counter = WIDTH; → ITER.
  - ITER: one shift-add (MULT) or restoring shift-subtract (DIV) step per cycle; counter decrements; the step that takes counter to 0 → FIN.
  - FIN: apply sign correction, write `hi`/`lo`, set `alu_out`=`lo`, pulse `out_valid` → IDLE.
- Arithmetic rules:
  - MULT: {hi,lo} = full 2·WIDTH-bit product.
  - DIV: lo = quotient, truncated toward zero; hi = remainder, with the sign of `a`.
  - Divide by zero: lo = all ones, hi = `a`. No trap.
  - Signed MIN / −1: lo = MIN, hi = 0.
- `hi`/`lo` change only in FIN or on reset. MFHI/MFLO read the current registered values.

## Timing
- Reset (edge with `rst_n`=0), including mid-operation:
  - state = IDLE; `out_valid`=0, `alu_out`=0, `overflow`=0, `hi`=`lo`=0.
  - Any in-flight MULT/DIV is discarded; no later `out_valid` for it.
- Single-cycle ops: accepted at edge E0 → `out_valid` high after E0 for exactly one cycle. Back-to-back issue gives one result every cycle.
- MULT/DIV: accepted at E0.
  - `in_ready` is low for WIDTH+1 cycles: WIDTH in ITER, 1 in FIN.
  - `out_valid` is high after edge E(WIDTH+1); `in_ready` returns high in that same cycle.
- `in_valid` held high while `in_ready`=0 has no effect. Operand changes during ITER/FIN are ignored.
- No output backpressure: the result must be consumed in its `out_valid` cycle.
- MFHI issued in the `out_valid` cycle of a MULT/DIV returns the new HI.

## Test plan
- ADD, `alu_ctl`=0x02, a=0x7FFFFFFF, b=1 → next cycle `out_valid`=1, `alu_out`=0x80000000, `overflow`=1. Same operands with 0x12 → `overflow`=0.
- b=0xF0000000, sa=4:
  - SRA → 0xFF000000; SRL → 0x0F000000; SLL → 0x00000000.
  - SLT a=0xFFFFFFFF, b=1 → 1; SLTU (0x17) → 0.
- MULT a=0xFFFFFFFD (−3), b=7:
  - `in_ready` low 33 cycles; then `out_valid`, `hi`=0xFFFFFFFF, `lo`=`alu_out`=0xFFFFFFEB.
  - Following MFHI → 0xFFFFFFFF next cycle.
- DIV a=0xFFFFFFF9 (−7), b=2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIVU a=7, b=0 → `lo`=0xFFFFFFFF, `hi`=7.
- MULTU 0xFFFFFFFF×0xFFFFFFFF with `in_valid` held high on an ADD during the busy window:
  - `hi`=0xFFFFFFFE, `lo`=0x00000001.
  - ADD accepted only in the `out_valid` cycle; its result appears the next cycle.
- `rst_n`=0 for one edge at ITER step 10 of a MULT → `out_valid`=0, `hi`=`lo`=0, `in_ready`=1. No `out_valid` in the following 40 cycles.
